uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter among NUM_REQ requesters, one byte at a time. Uses round-robin arbitration with message locking, so a multi-byte message from one requester is never interleaved with another's. Sits between the requesting client logic and the uart_tx instance that drives o_Tx_Serial. It issues one Tx_DV pulse per byte and waits for the transmitter's Tx_Done before issuing the next.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT_CYCLES, 65535: limit on WAIT-state cycles; used only with UART_ARB_TIMEOUT_EN.
- i_Clock  in  1  system clock; single clock domain.
- i_Reset  in  1  reset; synchronous, active-high.
- i_Req_Valid  in  NUM_REQ  per-requester byte valid.
- i_Req_Byte  in  8*NUM_REQ  requester k occupies bits [8k+7:8k].
- i_Req_Last  in  NUM_REQ  byte is the final byte of the requester's message.
- o_Req_Ready  out  NUM_REQ  one-hot; a byte transfers on a clock edge where valid and ready are both high.
- o_Tx_DV  out  1  one-cycle pulse to uart_tx.
- o_Tx_Byte  out  8  byte for uart_tx; valid while o_Tx_DV is high, held afterwards.
- i_Tx_Active  in  1  uart_tx busy; status only.
- i_Tx_Done  in  1  uart_tx frame-complete pulse.
- o_Grant  out  NUM_REQ  one-hot current message owner; all zeros when idle.
- o_Busy  out  1  high whenever the state is not IDLE.
- o_Timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States:
  - IDLE: no owner.
  - SEND: owner granted, waiting for its byte.
  - WAIT: byte issued, waiting for i_Tx_Done.
- IDLE:
  - If any i_Req_Valid bit is high, pick the first valid requester searching from the pointer p upward, with wrap-around.
  - Register the winner into o_Grant and go to SEND.
  - If no requester is valid, stay in IDLE.
- SEND:
  - o_Req_Ready = o_Grant (combinational from state and grant).
  - On a handshake: latch the byte into o_Tx_Byte, pulse o_Tx_DV the next cycle, record i_Req_Last, go to WAIT.
  - If the owner's valid is low, hold in SEND with the grant locked. Other requesters remain blocked.
- WAIT:
  - o_Req_Ready is all zeros.
  - On i_Tx_Done with the recorded last flag = 1: clear o_Grant, set p = (owner+1) mod NUM_REQ, go to IDLE.
  - On i_Tx_Done with the recorded last flag = 0: go to SEND, same owner.
- i_Tx_Done is ignored in IDLE and SEND.
- i_Tx_Active is not used for sequencing.

## Timing
- Reset values:
  - State IDLE, p = 0.
  - o_Grant, o_Req_Ready, o_Tx_DV, o_Busy, o_Timeout = 0.
  - o_Tx_Byte = 8'h00.
- Reset mid-message: state returns to IDLE on the next edge. The UART frame already in flight is not aborted, and its later i_Tx_Done is ignored.
- First-byte latency: valid at cycle 0 (idle) -> grant and ready at cycle 1 -> o_Tx_DV at cycle 2.
- Inter-byte latency: i_Tx_Done at cycle d -> ready at d+1 -> o_Tx_DV at d+2 (if the owner's valid is already high).
- o_Tx_DV is exactly one cycle wide, and there is exactly one pulse per handshake.
- Round-robin fairness: with all NUM_REQ requesters continuously valid and sending 1-byte messages, owners repeat the cycle 0,1,...,NUM_REQ-1.
- A requester's valid rising while another owns the grant waits until that message's last byte completes.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT and clears on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without i_Tx_Done: pulse o_Timeout for one cycle, release the grant, advance p as for a last byte, go to IDLE.
  - A simultaneous i_Tx_Done at the same edge takes priority (normal completion, no o_Timeout pulse).
- UART_ARB_TIMEOUT_EN undefined:
  - No counter is built, and o_Timeout is tied to 0.
  - The arbiter waits in WAIT indefinitely.

## Structure
- Shared include/package uart_pkg:
  - State encodings ST_IDLE/ST_SEND/ST_WAIT.
  - Byte width constant UART_BYTE_W = 8.
- Sub-module uart_rr_picker: combinational one-hot round-robin select.
  - Inputs: request vector and pointer p.
  - Outputs: one-hot winner and its index.
- Watchdog logic stays inline under the macro.

## Test plan
- Single byte: req0 sends 8'hA5 with last=1 -> o_Tx_DV at cycle 2, o_Tx_Byte=8'hA5, o_Grant=0001. After i_Tx_Done: o_Grant=0000, p=1.
- Message lock: req1 sends 3-byte message 11,22,33 while req2 is continuously valid with 8'h44 -> Tx order 11,22,33,44. o_Req_Ready[2] stays low until req1's last i_Tx_Done.
- Round-robin: all four requesters valid with 1-byte messages 0x10..0x13 -> Tx order 10,11,12,13,10. No requester is granted twice in a row.
- Owner stall: req3 drops valid for 20 cycles mid-message -> arbiter holds SEND, o_Grant=1000, no o_Tx_DV. Resumes when valid returns.
- Reset during WAIT: assert i_Reset one cycle -> next cycle all outputs are at reset values. The stale i_Tx_Done that follows causes no o_Tx_DV.
- Timeout (macro defined, TIMEOUT_CYCLES=50): withhold i_Tx_Done -> o_Timeout pulses 50 cycles after entering WAIT, grant released, next requester served.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// byte width, and the round-robin pointer advance helper.
// Pure declarations; no logic, no latency, no flow control.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no owner
        ST_SEND = 2'd1,   // owner granted, waiting for its byte
        ST_WAIT = 2'd2    // byte issued, waiting for the frame to finish
    } arb_state_t;

    // Pointer value after owner idx finishes: the next requester, wrapping.
    function automatic int rr_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bus of the UART transmit arbiter: per-requester valid,
// byte and last-flag, with the arbiter's one-hot ready coming back.
// A byte moves on a clock edge where Req_Valid[k] and Req_Ready[k] are both high.
//   master : client logic (drives valid/byte/last, receives ready)
//   slave  : arbiter      (receives valid/byte/last, drives ready)
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]             Req_Valid;
    logic [UART_BYTE_W*NUM_REQ-1:0] Req_Byte;   // requester k at [8k+7:8k]
    logic [NUM_REQ-1:0]             Req_Last;
    logic [NUM_REQ-1:0]             Req_Ready;

    modport master (output Req_Valid, Req_Byte, Req_Last, input Req_Ready);
    modport slave  (input Req_Valid, Req_Byte, Req_Last, output Req_Ready);

endinterface

// File: rtl/uart_rr_picker.sv
// Round-robin selector: first set bit of i_Req searching upward from i_Ptr, with wrap.
// Purely combinational, zero latency; no flow control.
// Ports: i_Req request vector, i_Ptr search start, o_Onehot/o_Idx winner, o_Any any request.
module uart_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [PW-1:0]      i_Ptr,
    output logic [NUM_REQ-1:0] o_Onehot,
    output logic [PW-1:0]      o_Idx,
    output logic               o_Any
);

    int w_k;

    // Walk offsets from farthest to nearest so the nearest valid requester
    // (smallest offset from the pointer) is the last one written and wins.
    always_comb begin
        o_Onehot = '0;
        o_Idx    = '0;
        o_Any    = |i_Req;
        w_k      = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_k = (int'(i_Ptr) + off) % NUM_REQ;
            if (i_Req[w_k]) begin
                o_Onehot      = '0;
                o_Onehot[w_k] = 1'b1;
                o_Idx         = PW'(w_k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters, round-robin, locked per message.
// Latency: request -> grant/ready 1 cycle -> o_Tx_DV 1 cycle after handshake; Tx_Done -> ready next cycle.
// Backpressure: only the owner sees ready, and only in SEND; every other requester holds until the owner's last byte completes.
// Ports: i_Clock, i_Reset (sync, active-high); i_Req (slave bus: valid/byte/last in, ready out);
//        o_Tx_DV/o_Tx_Byte to uart_tx; i_Tx_Active/i_Tx_Done from uart_tx; o_Grant, o_Busy, o_Timeout status.
// Optional: define UART_ARB_TIMEOUT_EN to build the WAIT-state watchdog (TIMEOUT_CYCLES).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    uart_tx_arbiter_if.slave       i_Req,
    output logic                   o_Tx_DV,
    output logic [UART_BYTE_W-1:0] o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_t             r_State;
    arb_state_t             w_Next_State;
    logic [NUM_REQ-1:0]     r_Grant;
    logic [PW-1:0]          r_Owner_Idx;
    logic [PW-1:0]          r_Ptr;
    logic                   r_Last;
    logic                   r_Tx_DV;
    logic [UART_BYTE_W-1:0] r_Tx_Byte;

    logic [NUM_REQ-1:0]     w_Ready;
    logic                   w_Handshake;
    logic                   w_Release;
    logic                   w_Wd_Expired;
    logic [NUM_REQ-1:0]     w_Pick_Onehot;
    logic [PW-1:0]          w_Pick_Idx;
    logic                   w_Pick_Any;
    logic [UART_BYTE_W-1:0] w_Owner_Byte;

    // Transmitter busy flag is status only; sequencing relies on Tx_Done.
    logic w_unused_tx_active;
    assign w_unused_tx_active = i_Tx_Active;

    uart_rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_picker (
        .i_Req    (i_Req.Req_Valid),
        .i_Ptr    (r_Ptr),
        .o_Onehot (w_Pick_Onehot),
        .o_Idx    (w_Pick_Idx),
        .o_Any    (w_Pick_Any)
    );

    assign w_Owner_Byte = i_Req.Req_Byte[int'(r_Owner_Idx) * UART_BYTE_W +: UART_BYTE_W];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_State <= ST_IDLE;
        else         r_State <= w_Next_State;
    end

    always_comb begin
        w_Next_State = r_State;
        w_Ready      = '0;
        w_Handshake  = 1'b0;
        w_Release    = 1'b0;
        case (r_State)
            ST_IDLE: begin
                if (w_Pick_Any) w_Next_State = ST_SEND;
            end
            ST_SEND: begin
                w_Ready = r_Grant;
                // Owner stalling keeps the grant; nobody else can get in.
                if (i_Req.Req_Valid[r_Owner_Idx]) begin
                    w_Handshake  = 1'b1;
                    w_Next_State = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion on the same edge as watchdog expiry wins.
                if (i_Tx_Done) begin
                    if (r_Last) begin
                        w_Release    = 1'b1;
                        w_Next_State = ST_IDLE;
                    end else begin
                        w_Next_State = ST_SEND;
                    end
                end else if (w_Wd_Expired) begin
                    w_Release    = 1'b1;
                    w_Next_State = ST_IDLE;
                end
            end
            default: w_Next_State = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Grant     <= '0;
            r_Owner_Idx <= '0;
            r_Ptr       <= '0;
            r_Last      <= 1'b0;
            r_Tx_DV     <= 1'b0;
            r_Tx_Byte   <= '0;
        end else begin
            r_Tx_DV <= w_Handshake;
            if (r_State == ST_IDLE && w_Pick_Any) begin
                r_Grant     <= w_Pick_Onehot;
                r_Owner_Idx <= w_Pick_Idx;
            end
            if (w_Handshake) begin
                r_Tx_Byte <= w_Owner_Byte;
                r_Last    <= i_Req.Req_Last[r_Owner_Idx];
            end
            if (w_Release) begin
                r_Grant <= '0;
                r_Ptr   <= PW'(rr_next(int'(r_Owner_Idx), NUM_REQ));
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_Wd_Cnt;
    logic          r_Timeout;

    // Counter holds k during the (k+1)th WAIT cycle, so expiry on the
    // TIMEOUT_CYCLES-th WAIT cycle puts the pulse TIMEOUT_CYCLES after entry.
    assign w_Wd_Expired = (r_State == ST_WAIT) && (r_Wd_Cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Wd_Cnt  <= '0;
            r_Timeout <= 1'b0;
        end else begin
            r_Timeout <= w_Wd_Expired && !i_Tx_Done;
            if (w_Handshake)             r_Wd_Cnt <= '0;
            else if (r_State == ST_WAIT) r_Wd_Cnt <= r_Wd_Cnt + 1'b1;
        end
    end

    assign o_Timeout = r_Timeout;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_Wd_Expired = 1'b0;
    assign o_Timeout    = 1'b0;
`endif

    assign i_Req.Req_Ready = w_Ready;
    assign o_Tx_DV         = r_Tx_DV;
    assign o_Tx_Byte       = r_Tx_Byte;
    assign o_Grant         = r_Grant;
    assign o_Busy          = (r_State != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a uart_tx stand-in, and an
// ordered scoreboard of {owner, byte} compared on every o_Tx_DV pulse.
// Latency and blocking checks are done inline in each scenario task.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_active, tx_done;
    logic         o_Tx_DV, o_Busy, o_Timeout;
    logic [7:0]   o_Tx_Byte;
    logic [N-1:0] o_Grant;

    int vectors = 0, miscompares = 0;
    int dv_count = 0, to_count = 0, tx_cnt = 0;
    bit tx_mute = 1'b0;
    bit prev_dv = 1'b0;

    logic [8:0]   rq [N][$];   // {last, byte} per requester
    logic [N-1:0] stall = '0;
    logic [9:0]   exp_q [$];   // {owner, byte} in expected transmit order
    logic [9:0]   mon_e;
    logic [N-1:0] drv_hs;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N)) req_if ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Req(req_if),
        .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Grant(o_Grant), .o_Busy(o_Busy), .o_Timeout(o_Timeout)
    );

    // Requesters: pop on handshake, present queue head unless stalled.
    initial begin
        req_if.Req_Valid = '0;
        req_if.Req_Byte  = '0;
        req_if.Req_Last  = '0;
        forever begin
            @(negedge clk);
            drv_hs = req_if.Req_Valid & req_if.Req_Ready;
            @(posedge clk);
            #2;
            for (int k = 0; k < N; k++) begin
                if (drv_hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
                if (rq[k].size() > 0 && !stall[k]) begin
                    req_if.Req_Valid[k]       = 1'b1;
                    req_if.Req_Byte[k*8 +: 8] = rq[k][0][7:0];
                    req_if.Req_Last[k]        = rq[k][0][8];
                end else begin
                    req_if.Req_Valid[k] = 1'b0;
                    req_if.Req_Last[k]  = 1'b0;
                end
            end
        end
    end

    // uart_tx stand-in: Tx_Done 4 cycles after each Tx_DV (suppressed when muted).
    initial begin
        tx_done = 1'b0;
        tx_active = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_active = 1'b0;
                    tx_done   = !tx_mute;
                end
            end else if (o_Tx_DV) begin
                tx_cnt    = 4;
                tx_active = 1'b1;
            end
        end
    end

    // Scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        if (o_Tx_DV) begin
            dv_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_unexpected: byte %h grant %b, nothing expected", o_Tx_Byte, o_Grant);
            end else begin
                mon_e = exp_q.pop_front();
                if (o_Tx_Byte !== mon_e[7:0] || o_Grant !== (N'(1) << mon_e[9:8])) begin
                    miscompares++;
                    $display("FAIL tx_order: got byte %h grant %b, want byte %h owner %0d",
                             o_Tx_Byte, o_Grant, mon_e[7:0], mon_e[9:8]);
                end
            end
            vectors++;
            if (prev_dv) begin
                miscompares++;
                $display("FAIL tx_dv_width: o_Tx_DV high %0d, want one-cycle pulse", 2);
            end
        end
        vectors++;
        if (req_if.Req_Ready !== '0 && req_if.Req_Ready !== o_Grant) begin
            miscompares++;
            $display("FAIL ready_vs_grant: ready %b grant %b", req_if.Req_Ready, o_Grant);
        end
        prev_dv = o_Tx_DV;
        if (o_Timeout) to_count++;
    end

    task automatic wait_drain(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_dv(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_Tx_DV) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        vectors++;
        if ({o_Grant, req_if.Req_Ready, o_Tx_DV, o_Busy, o_Timeout, o_Tx_Byte} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: grant %b ready %b dv %b busy %b to %b byte %h, want all 0",
                     o_Grant, req_if.Req_Ready, o_Tx_DV, o_Busy, o_Timeout, o_Tx_Byte);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_byte;
        bit ok;
        @(posedge clk);
        #1;
        rq[0].push_back({1'b1, 8'hA5});
        exp_q.push_back({2'd0, 8'hA5});
        @(posedge clk);
        #3;
        vectors++;
        if (o_Grant !== 4'b0001 || req_if.Req_Ready !== 4'b0001 || o_Tx_DV !== 1'b0) begin
            miscompares++;
            $display("FAIL single_cycle1: grant %b ready %b dv %b, want 0001 0001 0", o_Grant, req_if.Req_Ready, o_Tx_DV);
        end
        @(posedge clk);
        #3;
        vectors++;
        if (o_Tx_DV !== 1'b1 || o_Tx_Byte !== 8'hA5 || req_if.Req_Ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_cycle2: dv %b byte %h ready %b, want 1 a5 0000", o_Tx_DV, o_Tx_Byte, req_if.Req_Ready);
        end
        wait_drain(100, ok);
        vectors++;
        if (!ok || o_Grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_release: drained %b grant %b, want 1 0000", ok, o_Grant);
        end
        // Pointer now at 1: with req0 and req1 both waiting, req1 goes first.
        @(posedge clk);
        #1;
        rq[0].push_back({1'b1, 8'h5A});
        rq[1].push_back({1'b1, 8'hB1});
        exp_q.push_back({2'd1, 8'hB1});
        exp_q.push_back({2'd0, 8'h5A});
        wait_drain(200, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_ptr_drain: drained %b, want 1", ok);
        end
    endtask

    task automatic test_message_lock;
        bit ok = 1'b0, leak = 1'b0;
        @(posedge clk);
        #1;
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        rq[2].push_back({1'b1, 8'h44});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd1, 8'h22});
        exp_q.push_back({2'd1, 8'h33});
        exp_q.push_back({2'd2, 8'h44});
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_Grant === 4'b0010 && req_if.Req_Ready[2] !== 1'b0) leak = 1'b1;
            if (exp_q.size() == 0 && !o_Busy) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok || leak) begin
            miscompares++;
            $display("FAIL lock: drained %b ready2_leak %b, want 1 0", ok, leak);
        end
    endtask

    task automatic test_reset_in_wait;
        bit ok;
        int dv0;
        @(posedge clk);
        #1;
        rq[2].push_back({1'b1, 8'h55});
        exp_q.push_back({2'd2, 8'h55});
        wait_dv(50, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_wait_dv: saw dv %b, want 1", ok);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        vectors++;
        if ({o_Grant, req_if.Req_Ready, o_Tx_DV, o_Busy, o_Timeout, o_Tx_Byte} !== '0) begin
            miscompares++;
            $display("FAIL rst_wait_state: grant %b ready %b dv %b busy %b to %b byte %h, want all 0",
                     o_Grant, req_if.Req_Ready, o_Tx_DV, o_Busy, o_Timeout, o_Tx_Byte);
        end
        dv0 = dv_count;
        repeat (15) @(negedge clk);
        vectors++;
        if (dv_count !== dv0 || o_Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_stale_done: dv pulses %0d busy %b, want 0 0", dv_count - dv0, o_Busy);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        @(posedge clk);
        #1;
        rq[0].push_back({1'b1, 8'h10});
        rq[0].push_back({1'b1, 8'h10});
        rq[1].push_back({1'b1, 8'h11});
        rq[2].push_back({1'b1, 8'h12});
        rq[3].push_back({1'b1, 8'h13});
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd1, 8'h11});
        exp_q.push_back({2'd2, 8'h12});
        exp_q.push_back({2'd3, 8'h13});
        exp_q.push_back({2'd0, 8'h10});
        wait_drain(500, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rr_drain: drained %b, want 1", ok);
        end
    endtask

    task automatic test_owner_stall;
        bit ok, bad = 1'b0;
        int dv0;
        @(posedge clk);
        #1;
        rq[3].push_back({1'b0, 8'h31});
        rq[3].push_back({1'b0, 8'h32});
        rq[3].push_back({1'b1, 8'h33});
        exp_q.push_back({2'd3, 8'h31});
        exp_q.push_back({2'd3, 8'h32});
        exp_q.push_back({2'd3, 8'h33});
        exp_q.push_back({2'd0, 8'h66});
        wait_dv(50, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_first_dv: saw dv %b, want 1", ok);
        end
        @(posedge clk);
        #1;
        stall[3] = 1'b1;
        rq[0].push_back({1'b1, 8'h66});
        dv0 = dv_count;
        repeat (20) begin
            @(negedge clk);
            if (o_Grant !== 4'b1000) bad = 1'b1;
        end
        vectors++;
        if (bad || dv_count !== dv0 || req_if.Req_Ready !== 4'b1000 || o_Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_hold: grant_moved %b dv %0d ready %b busy %b, want 0 0 1000 1",
                     bad, dv_count - dv0, req_if.Req_Ready, o_Busy);
        end
        @(posedge clk);
        #1 stall[3] = 1'b0;
        wait_drain(300, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_resume: drained %b, want 1", ok);
        end
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        int n = 0;
        tx_mute = 1'b1;
        @(posedge clk);
        #1;
        rq[1].push_back({1'b1, 8'h77});
        rq[2].push_back({1'b1, 8'h78});
        exp_q.push_back({2'd1, 8'h77});
        exp_q.push_back({2'd2, 8'h78});
        wait_dv(50, ok);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (o_Timeout) break;
        end
        vectors++;
        if (!ok || n !== 50 || o_Grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL timeout_pulse: dv %b after %0d cycles grant %b, want 1 50 0000", ok, n, o_Grant);
        end
        @(posedge clk);
        #1 tx_mute = 1'b0;
        wait_drain(200, ok);
        vectors++;
        if (!ok || to_count !== 1) begin
            miscompares++;
            $display("FAIL timeout_next: drained %b pulses %0d, want 1 1", ok, to_count);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset;
        test_single_byte;
        test_message_lock;
        test_reset_in_wait;
        test_round_robin;
        test_owner_stall;
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout;
`else
        vectors++;
        if (to_count !== 0) begin
            miscompares++;
            $display("FAIL timeout_disabled: pulses %0d, want 0", to_count);
        end
`endif
        repeat (5) @(negedge clk);
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_left: %0d bytes never sent, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
